// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helpers for the QAM symbol-path FIFO.
package sync_fifo_pkg;

    localparam int QAM_DATA_W = 8;
    localparam int QAM_DEPTH  = 8;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_storage.sv
// Register-array storage for sync_fifo_param: synchronous write, combinational read.
module sync_fifo_storage
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = QAM_DATA_W,
    parameter int DEPTH  = QAM_DEPTH,
    parameter int AW     = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array is cleared on reset so a read after reset can never expose stale
    // symbols; this costs a reset net per flop and prevents RAM inference.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data and occupancy flags.
// Define SYNC_FIFO_ERR_EN to build the sticky wr_err/rd_err ports and logic.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = QAM_DATA_W,
    parameter int DEPTH    = QAM_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [cnt_w(DEPTH)-1:0]  count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                     wr_err,
    output logic                     rd_err
`endif
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic [DATA_W-1:0] mem_rdata;
    logic              wr_ok;
    logic              rd_ok;

    // Full gates writes and empty gates reads, which resolves both same-cycle corner cases.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    sync_fifo_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_storage (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // NOTE: count_nxt gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_data <= mem_rdata;
                rd_ptr  <= rd_ptr + AW'(1);
            end
            rd_valid     <= rd_ok;
            count        <= count_nxt;
            // Flags come from count_nxt so they change on the same edge as count.
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            if (wr_en && full) begin
                wr_err <= 1'b1;
            end
            if (rd_en && empty) begin
                rd_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=8) against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int AF_LVL = DEPTH - 2;
    localparam int AE_LVL = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [3:0]        count;
`ifdef SYNC_FIFO_ERR_EN
    logic              wr_err;
    logic              rd_err;
`endif

    sync_fifo_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LVL),
        .AE_LEVEL (AE_LVL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .wr_err       (wr_err),
        .rd_err       (rd_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus the expected output register state.
    logic [DATA_W-1:0] model_q [$];
    logic [DATA_W-1:0] exp_data  = '0;
    logic              exp_valid = 1'b0;
    logic              exp_wr_err = 1'b0;
    logic              exp_rd_err = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = model_q.size();
        check({tag, " count"},        64'(count),        64'(n));
        check({tag, " empty"},        64'(empty),        64'(n == 0));
        check({tag, " full"},         64'(full),         64'(n == DEPTH));
        check({tag, " almost_full"},  64'(almost_full),  64'(n >= AF_LVL));
        check({tag, " almost_empty"}, 64'(almost_empty), 64'(n <= AE_LVL));
        check({tag, " rd_valid"},     64'(rd_valid),     64'(exp_valid));
        check({tag, " rd_data"},      64'(rd_data),      64'(exp_data));
`ifdef SYNC_FIFO_ERR_EN
        check({tag, " wr_err"},       64'(wr_err),       64'(exp_wr_err));
        check({tag, " rd_err"},       64'(rd_err),       64'(exp_rd_err));
`endif
    endtask

    // One clock: drive requests at the falling edge, update the model, check 1 ns after the rise.
    task automatic step(input string tag, input logic w, input logic [DATA_W-1:0] d,
                        input logic r);
        logic wr_acc;
        logic rd_acc;
        @(negedge clk);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        wr_acc  = w && (model_q.size() < DEPTH);
        rd_acc  = r && (model_q.size() > 0);
        if (w && model_q.size() == DEPTH) exp_wr_err = 1'b1;
        if (r && model_q.size() == 0)     exp_rd_err = 1'b1;
        if (rd_acc) exp_data = model_q.pop_front();
        if (wr_acc) model_q.push_back(d);
        exp_valid = rd_acc;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic reset_cycle(input string tag);
        @(negedge clk);
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = DATA_W'($urandom);
        model_q.delete();
        exp_data   = '0;
        exp_valid  = 1'b0;
        exp_wr_err = 1'b0;
        exp_rd_err = 1'b0;
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] d;

        // Reset state.
        reset_cycle("reset");
        reset_cycle("reset2");

        // Fill with 0x11..0x88: count steps up, almost_full at 6, full at 8.
        for (int i = 1; i <= DEPTH; i++) begin
            step("fill", 1'b1, DATA_W'(i * 8'h11), 1'b0);
        end
        check("filled count literal", 64'(count), 64'd8);

        // Write when full is rejected.
        step("wr_at_full", 1'b1, 8'h99, 1'b0);
        step("wr_at_full2", 1'b1, 8'h99, 1'b0);

        // Drain in order, then one read past empty.
        for (int i = 1; i <= DEPTH; i++) begin
            step("drain", 1'b0, '0, 1'b1);
            check("drain order", 64'(rd_data), 64'(i * 8'h11));
        end
        step("rd_at_empty", 1'b0, '0, 1'b1);
        check("rd_data holds 0x88", 64'(rd_data), 64'h88);

        // Count 4, then 20 cycles of simultaneous read/write across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            step("pre4", 1'b1, DATA_W'($urandom), 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            step("stream", 1'b1, DATA_W'($urandom), 1'b1);
        end
        check("stream count literal", 64'(count), 64'd4);

        // Full with simultaneous read/write: read wins, write dropped.
        for (int i = 0; i < 4; i++) begin
            step("top_up", 1'b1, DATA_W'($urandom), 1'b0);
        end
        step("full_rw", 1'b1, 8'hA5, 1'b1);
        check("full_rw count literal", 64'(count), 64'd7);

        // Empty with simultaneous read/write: write wins, no fall-through.
        for (int i = 0; i < 7; i++) begin
            step("drain2", 1'b0, '0, 1'b1);
        end
        step("empty_rw", 1'b1, 8'h5A, 1'b1);
        check("empty_rw count literal", 64'(count), 64'd1);
        check("empty_rw no valid", 64'(rd_valid), 64'd0);

        // Mid-stream reset at count 5, then a fresh word goes through.
        for (int i = 0; i < 4; i++) begin
            step("to5", 1'b1, DATA_W'($urandom), 1'b0);
        end
        reset_cycle("mid_reset");
        step("post_rst_wr", 1'b1, 8'h3C, 1'b0);
        step("post_rst_rd", 1'b0, '0, 1'b1);
        check("post reset word", 64'(rd_data), 64'h3C);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            d = DATA_W'($urandom);
            step("random", 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock synchronous FIFO for the 64-QAM modulator datapath, replacing the fixed 8x8 register array plus external address logic. It owns its write/read pointers, occupancy count, full/empty and almost-full/almost-empty flags, and registered read data with a valid strobe. It sits between the bit-grouping stage and the symbol mapper, buffering symbol words at the modulator clock rate.

## Interface
- DATA_W, 8, width of each stored word (1..64)
- DEPTH, 8, number of entries; power of two, 2..256
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- rd_en  in  1  read request
- rd_data  out  DATA_W  read word, registered; holds last value when no read is accepted
- rd_valid  out  1  one-cycle pulse: rd_data updated this cycle
- full, empty  out  1 each  count == DEPTH / count == 0
- almost_full, almost_empty  out  1 each  threshold flags per parameters
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- wr_err, rd_err  out  1 each  sticky error flags (only with SYNC_FIFO_ERR_EN, see Configuration)

## Operation
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. No separate wrap bit; full and empty come from count.
- Write is accepted iff wr_en && !full. On acceptance, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read is accepted iff rd_en && !empty. On acceptance, rd_data <= mem[rd_ptr], rd_ptr increments and rd_valid = 1 on the next cycle.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Full and reading in the same cycle: the read is accepted and the write is rejected. Full blocks writes regardless of rd_en.
- Empty and writing in the same cycle: the write is accepted and the read is rejected. There is no fall-through.
- Rejected requests leave all state unchanged.
- Flags are registered outputs, derived from the next-state count so they are coincident with count.
- Reset (rst_n low at a clock edge), including mid-stream:
  - pointers, count, storage, rd_data, rd_valid, full, almost_full, wr_err and rd_err go to 0
  - empty and almost_empty go to 1
  - requests in the reset cycle are ignored

## Timing
- Write-to-read latency: a word written at edge N is readable (empty deasserted) after edge N and can be returned on rd_data at edge N+1 at the earliest.
- Read latency: 1 cycle, from accepted rd_en to rd_data/rd_valid.
- Flags and count reflect all accepted operations of edge N from edge N onward.
- Sustained throughput: one write and one read per cycle when neither full nor empty.

## Configuration
- SYNC_FIFO_ERR_EN defined:
  - wr_err sets on wr_en && full; rd_err sets on rd_en && empty
  - both are sticky until reset
- SYNC_FIFO_ERR_EN undefined:
  - wr_err and rd_err ports are absent
  - no error logic is built
  - rejected requests are silently dropped

## Structure
- Shared package sync_fifo_pkg:
  - addr_w/cnt_w helper functions
  - default DATA_W/DEPTH constants for the QAM symbol path
- Sub-module sync_fifo_storage:
  - parametrised register array, synchronous write port (we, waddr, wdata)
  - combinational read mux (raddr -> rdata), no reset of contents beyond the top-level reset input
- Top level holds pointers, count, flag and error logic, and the rd_data output register.

## Test plan
- Reset, then 8 writes 0x11..0x88 (DEPTH=8) -> count steps 1..8; almost_full at count 6; full at 8; empty 0.
- Full, then wr_en with 0x99 -> rejected, count stays 8; with ERR_EN, wr_err=1 and it stays set.
- 8 reads after fill -> rd_data 0x11..0x88 in order, rd_valid each cycle, empty after the 8th; a 9th rd_en gives rd_valid=0, rd_data holds 0x88, and rd_err=1.
- Count 4, simultaneous wr_en/rd_en for 20 cycles -> count stays 4, order is preserved across pointer wrap, data matches the reference queue.
- Full, simultaneous wr_en/rd_en -> read returns the oldest word, write rejected, count 7. Empty, simultaneous wr_en/rd_en -> write accepted, rd_valid=0, count 1.
- rst_n low for one cycle at count 5 -> next cycle count 0, empty=1, rd_data=0, errors cleared. A following write/read returns the new word.
